// File: rtl/apb_xfer_regbank_fifo.sv
// APB register bank for the serial transfer controller: slave address, W1C event
// status with maskable interrupt, and TX/RX byte FIFOs between APB and the core.
module apb_xfer_regbank_fifo #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int APB_DATA_WIDTH = 32,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [APB_ADDR_WIDTH-1:0] i_PADDR,
  input  logic [APB_DATA_WIDTH-1:0] i_PWDATA,
  input  logic                      i_PWRITE,
  input  logic                      i_PSEL,
  input  logic                      i_PENABLE,
  output logic [APB_DATA_WIDTH-1:0] o_PRDATA,
  output logic                      o_PREADY,
  output logic                      o_PSLVERR,
  output logic [6:0]                o_slvaddr,
  output logic                      o_tba,
  output logic                      o_tx_valid,
  output logic [7:0]                o_tx_data,
  input  logic                      i_tx_ready,
  input  logic                      i_rx_valid,
  input  logic [7:0]                i_rx_data,
  input  logic                      i_tra,
  input  logic                      i_nak,
  output logic                      o_irq
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic [APB_ADDR_WIDTH-1:0] A_ADDR   = APB_ADDR_WIDTH'(12'h000);
  localparam logic [APB_ADDR_WIDTH-1:0] A_STATUS = APB_ADDR_WIDTH'(12'h004);
  localparam logic [APB_ADDR_WIDTH-1:0] A_MASK   = APB_ADDR_WIDTH'(12'h008);
  localparam logic [APB_ADDR_WIDTH-1:0] A_TXDATA = APB_ADDR_WIDTH'(12'h00C);
  localparam logic [APB_ADDR_WIDTH-1:0] A_RXDATA = APB_ADDR_WIDTH'(12'h010);
  localparam logic [APB_ADDR_WIDTH-1:0] A_LEVEL  = APB_ADDR_WIDTH'(12'h014);

  logic [6:0]    slvaddr_reg;
  logic          tba_reg;
  logic [3:0]    status_reg, status_next, status_set, status_clr;
  logic [3:0]    mask_reg;
  logic          irq_reg;

  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [PW-1:0] tx_wr_ptr_reg, tx_rd_ptr_reg;
  logic [CW-1:0] tx_cnt_reg;
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [PW-1:0] rx_wr_ptr_reg, rx_rd_ptr_reg;
  logic [CW-1:0] rx_cnt_reg;

  logic acc, wr_acc, rd_acc;
  logic sel_addr, sel_status, sel_mask, sel_txd, sel_rxd, sel_level, unmapped;
  logic tx_full, tx_empty, tx_push, tx_pop;
  logic rx_full, rx_empty, rx_push, rx_pop, rx_ovf;
  logic unused_pwdata;

  assign unused_pwdata = ^i_PWDATA[30:8];

  assign acc    = i_PSEL & i_PENABLE;
  assign wr_acc = acc & i_PWRITE;
  assign rd_acc = acc & ~i_PWRITE;

  assign sel_addr   = (i_PADDR == A_ADDR);
  assign sel_status = (i_PADDR == A_STATUS);
  assign sel_mask   = (i_PADDR == A_MASK);
  assign sel_txd    = (i_PADDR == A_TXDATA);
  assign sel_rxd    = (i_PADDR == A_RXDATA);
  assign sel_level  = (i_PADDR == A_LEVEL);
  assign unmapped   = ~(sel_addr | sel_status | sel_mask | sel_txd | sel_rxd | sel_level);

  // A full FIFO still accepts a push when its head leaves in the same cycle.
  assign tx_full  = (tx_cnt_reg == CW'(FIFO_DEPTH));
  assign tx_empty = (tx_cnt_reg == '0);
  assign tx_pop   = ~tx_empty & i_tx_ready;
  assign tx_push  = wr_acc & sel_txd & (~tx_full | tx_pop);

  assign rx_full  = (rx_cnt_reg == CW'(FIFO_DEPTH));
  assign rx_empty = (rx_cnt_reg == '0);
  assign rx_pop   = rd_acc & sel_rxd & ~rx_empty;
  assign rx_push  = i_rx_valid & (~rx_full | rx_pop);
  assign rx_ovf   = i_rx_valid & rx_full & ~rx_pop;

  assign status_set = {rx_ovf, rx_push, i_tra, i_nak};
  assign status_clr = (wr_acc & sel_status) ? i_PWDATA[3:0] : 4'h0;

  // Set has priority over a same-cycle write-one-to-clear.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_status
      assign status_next[gi] = status_set[gi] | (status_reg[gi] & ~status_clr[gi]);
    end
  endgenerate

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      slvaddr_reg   <= '0;
      tba_reg       <= 1'b0;
      status_reg    <= '0;
      mask_reg      <= '0;
      irq_reg       <= 1'b0;
      tx_wr_ptr_reg <= '0;
      tx_rd_ptr_reg <= '0;
      tx_cnt_reg    <= '0;
      rx_wr_ptr_reg <= '0;
      rx_rd_ptr_reg <= '0;
      rx_cnt_reg    <= '0;
    end else begin
      if (wr_acc && sel_addr) begin
        slvaddr_reg <= i_PWDATA[6:0];
        tba_reg     <= i_PWDATA[31];
      end
      if (wr_acc && sel_mask) mask_reg <= i_PWDATA[3:0];
      status_reg <= status_next;
      irq_reg    <= |(status_reg & mask_reg);
      if (tx_push) tx_wr_ptr_reg <= tx_wr_ptr_reg + PW'(1);
      if (tx_pop)  tx_rd_ptr_reg <= tx_rd_ptr_reg + PW'(1);
      tx_cnt_reg <= tx_cnt_reg + CW'(tx_push) - CW'(tx_pop);
      if (rx_push) rx_wr_ptr_reg <= rx_wr_ptr_reg + PW'(1);
      if (rx_pop)  rx_rd_ptr_reg <= rx_rd_ptr_reg + PW'(1);
      rx_cnt_reg <= rx_cnt_reg + CW'(rx_push) - CW'(rx_pop);
    end
  end

  // Storage carries no reset; stale entries are unreachable once counts clear.
  always_ff @(posedge HCLK) begin
    if (tx_push) tx_mem[tx_wr_ptr_reg] <= i_PWDATA[7:0];
    if (rx_push) rx_mem[rx_wr_ptr_reg] <= i_rx_data;
  end

  always_comb begin
    o_PRDATA = '0;
    if (sel_addr)        o_PRDATA = {tba_reg, 24'h0, slvaddr_reg};
    else if (sel_status) o_PRDATA = {26'h0, rx_empty, tx_full, status_reg};
    else if (sel_mask)   o_PRDATA = {28'h0, mask_reg};
    else if (sel_rxd && !rx_empty) o_PRDATA = {24'h0, rx_mem[rx_rd_ptr_reg]};
    else if (sel_level)  o_PRDATA = {16'h0, 8'(rx_cnt_reg), 8'(tx_cnt_reg)};
  end

  assign o_PSLVERR = acc & (unmapped
                          | (sel_txd & ~i_PWRITE)
                          | (sel_txd & i_PWRITE & tx_full & ~tx_pop)
                          | (sel_rxd & ~i_PWRITE & rx_empty));

  assign o_PREADY   = 1'b1;
  assign o_slvaddr  = slvaddr_reg;
  assign o_tba      = tba_reg;
  assign o_tx_valid = ~tx_empty;
  assign o_tx_data  = tx_empty ? 8'h00 : tx_mem[tx_rd_ptr_reg];
  assign o_irq      = irq_reg;

endmodule
